// File: rtl/stack_pkg.sv
// Shared constants, request encoding and pointer sizing for the LIFO stack.
package stack_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Encoding matches the {push,pop} request pair directly
   typedef enum logic [1:0] {
      OP_NONE    = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } op_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH flop array: one synchronous write port, two asynchronous read ports.
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are never reset; only the pointer decides what is valid
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_lifo.sv
// LIFO data stack with registered show-ahead top-of-stack and full/empty/count.
// Optional sticky overflow/underflow flags enabled by defining STACK_ERR_FLAGS_EN.
module stack_lifo
   import stack_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [WIDTH-1:0]          data_in,
   output logic [WIDTH-1:0]          data_out,
   output logic                      full,
   output logic                      empty,
   output logic [ptr_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      err_clr
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    sp, sp_next, sp_m1, sp_m2;
   logic [AW-1:0]    waddr;
   logic             we;
   logic [WIDTH-1:0] rd_top, rd_below, dout_next;
   logic             is_full, is_empty, ovf_set, unf_set;
   op_t              op;

   assign op       = op_t'({push, pop});
   assign sp_m1    = sp - PW'(1);
   assign sp_m2    = sp - PW'(2);
   assign is_full  = (sp == PW'(DEPTH));
   assign is_empty = (sp == '0);

   stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
      .clk     (clk),
      .we      (we & ~reset),
      .waddr   (waddr),
      .wdata   (data_in),
      .raddr_a (sp_m1[AW-1:0]),
      .raddr_b (sp_m2[AW-1:0]),
      .rdata_a (rd_top),
      .rdata_b (rd_below)
   );

   always_comb begin
      sp_next   = sp;
      dout_next = is_empty ? '0 : rd_top;
      we        = 1'b0;
      waddr     = sp[AW-1:0];
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      unique case (op)
         OP_PUSH: begin
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               we        = 1'b1;
               sp_next   = sp + PW'(1);
               dout_next = data_in;
            end
         end
         OP_POP: begin
            if (is_empty) begin
               unf_set = 1'b1;
            end else begin
               sp_next   = sp_m1;
               dout_next = (sp >= PW'(2)) ? rd_below : '0;
            end
         end
         OP_REPLACE: begin
            // Empty replace degrades to a plain push with the pop part refused
            we        = 1'b1;
            dout_next = data_in;
            if (is_empty) begin
               unf_set = 1'b1;
               sp_next = PW'(1);
            end else begin
               waddr = sp_m1[AW-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp       <= '0;
         data_out <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         sp       <= sp_next;
         data_out <= dout_next;
         full     <= (sp_next == PW'(DEPTH));
         empty    <= (sp_next == '0);
      end
   end

   assign count = sp;

`ifdef STACK_ERR_FLAGS_EN
   // A new violation in the same cycle as err_clr keeps the flag set
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (err_clr) overflow <= 1'b0;
         if (unf_set)      underflow <= 1'b1;
         else if (err_clr) underflow <= 1'b0;
      end
   end
`else
   logic unused_err;
   assign unused_err = ^{err_clr, ovf_set, unf_set};
   assign overflow   = 1'b0;
   assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: directed scenarios plus randomized traffic
// checked against a queue-based LIFO reference model.
module tb_stack_lifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam int VW    = WIDTH + PW + 4;
`ifdef STACK_ERR_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             full, empty, overflow, underflow;
   logic [PW-1:0]    count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [WIDTH-1:0] q[$];
   bit               m_ovf, m_unf;

   stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] exp_vec();
      logic [WIDTH-1:0] top;
      top = (q.size() == 0) ? '0 : q[q.size()-1];
      return {top, PW'(q.size()), q.size() == DEPTH, q.size() == 0,
              FLAGS_EN & m_ovf, FLAGS_EN & m_unf};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {data_out, count, full, empty, overflow, underflow};
   endfunction

   task automatic model_update(input bit p, input bit po, input logic [WIDTH-1:0] d,
                               input bit c, input bit r);
      bit ovf_new, unf_new;
      ovf_new = 0;
      unf_new = 0;
      if (r) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
         if (p && !po) begin
            if (q.size() == DEPTH) ovf_new = 1;
            else q.push_back(d);
         end else if (po && !p) begin
            if (q.size() == 0) unf_new = 1;
            else void'(q.pop_back());
         end else if (p && po) begin
            if (q.size() == 0) begin
               unf_new = 1;
               q.push_back(d);
            end else begin
               q[q.size()-1] = d;
            end
         end
         if (ovf_new) m_ovf = 1; else if (c) m_ovf = 0;
         if (unf_new) m_unf = 1; else if (c) m_unf = 0;
      end
   endtask

   // Apply one request for one edge, advance the model, sample 1ns after the edge
   task automatic step(input bit p, input bit po, input logic [WIDTH-1:0] d,
                       input bit c = 0, input bit r = 0);
      push    = p;
      pop     = po;
      data_in = d;
      err_clr = c;
      reset   = r;
      @(posedge clk);
      model_update(p, po, d, c, r);
      #1;
      push    = 0;
      pop     = 0;
      err_clr = 0;
      reset   = 0;
   endtask

   task automatic test_reset();
      step(0, 0, 8'h00, 0, 1);
      step(0, 0, 8'h00, 0, 1);
      n_tests++;
      if (obs_vec() !== {8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got %h required %h", obs_vec(),
                  {8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_push_pop();
      logic [WIDTH-1:0] exp_pop [3] = '{8'h22, 8'h11, 8'h00};
      step(1, 0, 8'h11);
      step(1, 0, 8'h22);
      step(1, 0, 8'h33);
      n_tests++;
      if (count !== 5'd3 || data_out !== 8'h33 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL push3: got count=%0d dout=%h empty=%b required 3 33 0",
                  count, data_out, empty);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'h00);
         n_tests++;
         if (data_out !== exp_pop[i]) begin
            n_fail++;
            $display("FAIL pop_walk[%0d]: got %h required %h", i, data_out, exp_pop[i]);
         end
      end
      n_tests++;
      if (empty !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL pop_to_empty: got %h required %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(i));
      n_tests++;
      if (full !== 1'b1 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL fill: got full=%b count=%0d required 1 16", full, count);
      end
      step(1, 0, 8'hAA);
      n_tests++;
      if (count !== 5'd16 || data_out !== 8'h0F || overflow !== FLAGS_EN) begin
         n_fail++;
         $display("FAIL overflow: got count=%0d dout=%h ovf=%b required 16 0f %b",
                  count, data_out, overflow, FLAGS_EN);
      end
      step(0, 0, 8'h00, 1);
      n_tests++;
      if (overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL err_clr: got %h required %h", obs_vec(), exp_vec());
      end
      step(1, 1, 8'h99);
      n_tests++;
      if (count !== 5'd16 || data_out !== 8'h99 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL replace_full: got count=%0d dout=%h ovf=%b required 16 99 0",
                  count, data_out, overflow);
      end
      // New error in the same cycle as err_clr must win
      step(1, 0, 8'h55, 1);
      n_tests++;
      if (overflow !== FLAGS_EN || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL err_clr_vs_set: got %h required %h", obs_vec(), exp_vec());
      end
      step(0, 1, 8'h00);
      n_tests++;
      if (data_out !== 8'h0E || count !== 5'd15) begin
         n_fail++;
         $display("FAIL pop_after_full: got dout=%h count=%0d required 0e 15", data_out, count);
      end
   endtask

   task automatic test_underflow();
      step(0, 0, 8'h00, 0, 1);
      step(0, 1, 8'h00);
      n_tests++;
      if (count !== 5'd0 || data_out !== 8'h00 || underflow !== FLAGS_EN) begin
         n_fail++;
         $display("FAIL underflow: got count=%0d dout=%h unf=%b required 0 00 %b",
                  count, data_out, underflow, FLAGS_EN);
      end
      step(1, 0, 8'h5A);
      n_tests++;
      if (data_out !== 8'h5A || count !== 5'd1 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL push_after_underflow: got %h required %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_replace();
      step(0, 0, 8'h00, 0, 1);
      step(1, 0, 8'h03);
      step(1, 0, 8'h04);
      step(1, 1, 8'h07);
      n_tests++;
      if (count !== 5'd2 || data_out !== 8'h07) begin
         n_fail++;
         $display("FAIL replace: got count=%0d dout=%h required 2 07", count, data_out);
      end
      step(0, 1, 8'h00);
      n_tests++;
      if (data_out !== 8'h03) begin
         n_fail++;
         $display("FAIL replace_pop: got %h required 03", data_out);
      end
      step(0, 1, 8'h00);
      step(1, 1, 8'h6C);
      n_tests++;
      if (obs_vec() !== exp_vec() || count !== 5'd1 || data_out !== 8'h6C) begin
         n_fail++;
         $display("FAIL replace_empty: got %h required %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_with_push();
      step(1, 0, 8'h44, 0, 1);
      n_tests++;
      if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_wins: got count=%0d empty=%b dout=%h required 0 1 00",
                  count, empty, data_out);
      end
      // A dropped write must not leak into the array
      step(1, 0, 8'h21);
      step(1, 0, 8'h22);
      step(0, 1, 8'h00);
      n_tests++;
      if (data_out !== 8'h21 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL reset_no_write: got dout=%h count=%0d required 21 1", data_out, count);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 800; i++) begin
         int r;
         bit p, po;
         r  = $urandom_range(0, 99);
         p  = (r < 45) || (r >= 80 && r < 92);
         po = (r >= 45 && r < 92);
         step(p, po, WIDTH'($urandom), $urandom_range(0, 19) == 0,
              $urandom_range(0, 199) == 0);
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL random[%0d]: got %h required %h", i, obs_vec(), exp_vec());
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_replace();
      test_reset_with_push();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
